convertidor_bcd_serial: RTL and testbench
=========================================

CONVERTIDOR_BCD_SERIAL -- requirements
Module: convertidor_bcd_serial

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is synchronous and active-high.
REQ-002 Parameter WIDTH SHALL default to 10 and sets the binary input width (legal range 4..32).
REQ-003 Parameter DIGITS SHALL default to 4 and sets the number of BCD output digits (legal range 1..10).
REQ-004 clk SHALL be an input, 1 bit wide, and is the rising-edge clock.
REQ-005 rst SHALL be an input, 1 bit wide, and is the synchronous active-high reset.
REQ-006 start SHALL be an input, 1 bit wide, and is the request to convert bin.
REQ-007 bin SHALL be an input, WIDTH bits wide, and is the unsigned binary value to convert.
REQ-008 busy SHALL be an output, 1 bit wide, and is high while a conversion is in progress.
REQ-009 done SHALL be an output, 1 bit wide, and is a one-cycle pulse that marks a new result.
REQ-010 bcd SHALL be an output, 4*DIGITS bits wide; digit i occupies bits [4i+3:4i] and digit 0 is the units digit.
REQ-011 overflow SHALL be an output, 1 bit wide, and is high when the value exceeded 10^DIGITS-1.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1, the block SHALL capture bin into a shift register, clear the BCD scratch and the overflow scratch, load the bit counter with WIDTH and go to SHIFT.
REQ-014 Each SHIFT cycle SHALL first add 3 to every scratch digit that is >=5, then shift the {scratch, shift register} pair left by one bit, inserting the bin MSB into digit 0 bit 0.
REQ-015 Any 1 shifted out of the top scratch digit SHALL set the overflow scratch.
REQ-016 After WIDTH shift cycles, the final shift edge SHALL register the scratch into bcd, register the overflow scratch into overflow, and move the FSM to DONE.
REQ-017 done SHALL be high only in DONE, which lasts exactly 1 cycle before the FSM returns to IDLE.
REQ-018 Latency: if start is sampled at edge k, done SHALL be high in the cycle following edge k+WIDTH.
REQ-019 busy SHALL be 1 only in SHIFT.
REQ-020 The block SHALL sustain a throughput of one conversion per WIDTH+2 cycles.
REQ-021 start SHALL be ignored in SHIFT and in DONE; bin SHALL be sampled only at acceptance.
REQ-022 bcd and overflow SHALL hold their last values until the next DONE.
REQ-023 On overflow, bcd SHALL equal the input value modulo 10^DIGITS.
REQ-024 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL never wrap.

Reset
REQ-025 When rst=1 at a clock edge, the FSM SHALL go to IDLE and the outputs SHALL become busy=0, done=0, bcd=0, overflow=0, with the scratch and counter cleared.
REQ-026 rst SHALL take priority over start in the same cycle.
REQ-027 rst asserted during SHIFT SHALL abort the conversion with no done pulse.

Configuration
REQ-028 Macro CONVERTIDOR_BLANK_EN SHALL control leading-zero blanking, applied at result registration.
REQ-029 With CONVERTIDOR_BLANK_EN defined, every digit above the most significant nonzero digit SHALL be output as 4'hF, digit 0 SHALL never be blanked, and overflow SHALL be unaffected.
REQ-030 Without CONVERTIDOR_BLANK_EN, bcd SHALL be plain BCD including leading zeros.

Verification
REQ-031 Defaults, bin=0, start pulse: done SHALL pulse exactly 1 cycle, 10 cycles after acceptance, with bcd=16'h0000 and overflow=0.
REQ-032 Defaults, bin=999: bcd SHALL be 16'h0999; with CONVERTIDOR_BLANK_EN it SHALL be 16'hF999.
REQ-033 Defaults, bin=1023: bcd SHALL be 16'h1023 and overflow=0; bin=7 with blanking SHALL give 16'hFFF7.
REQ-034 DIGITS=3, bin=1000: overflow SHALL be 1 and bcd SHALL be 12'h000; bin=1015 SHALL give bcd=12'h015 with overflow=1.
REQ-035 start with bin=42, then start with bin=500 during SHIFT: the second start SHALL be ignored, a single done SHALL occur with bcd=16'h0042, and busy SHALL drop before done.
REQ-036 rst at the 5th SHIFT cycle: no done SHALL occur, all outputs SHALL be 0, and a following start with bin=321 SHALL give 16'h0321.

Source files
------------

// File: rtl/convertidor_bcd_serial.sv
// Serial binary-to-BCD converter (shift-and-add-3), one result bit per clock.
// Optional leading-zero blanking of the result is enabled by defining CONVERTIDOR_BLANK_EN.
module convertidor_bcd_serial #(
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]   scratch_q, scratch_d;
    logic            ovf_scr_q, ovf_scr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            overflow_q, overflow_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [BW-1:0]   adj;
    logic [BW-1:0]   shifted;
    logic            carry;
    logic [3:0]      dig;

`ifdef CONVERTIDOR_BLANK_EN
    // Replace every zero digit above the most significant nonzero digit with 4'hF.
    function automatic logic [BW-1:0] blank(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          nz;
        r  = v;
        nz = 1'b0;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            if (v[4*i +: 4] != 4'd0) nz = 1'b1;
            if (!nz) r[4*i +: 4] = 4'hF;
        end
        return r;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            scratch_q  <= '0;
            ovf_scr_q  <= 1'b0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            scratch_q  <= scratch_d;
            ovf_scr_q  <= ovf_scr_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        ovf_scr_d  = ovf_scr_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        adj        = '0;
        dig        = '0;

        // Add-3 correction of every digit, then one-bit left shift of {scratch, shreg}.
        for (int i = 0; i < int'(DIGITS); i++) begin
            dig          = scratch_q[4*i +: 4];
            adj[4*i +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
        end
        shifted = {adj[BW-2:0], shreg_q[WIDTH-1]};
        carry   = adj[BW-1];

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d   = bin;
                    scratch_d = '0;
                    ovf_scr_d = 1'b0;
                    cnt_d     = CW'(WIDTH);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                scratch_d = shifted;
                ovf_scr_d = ovf_scr_q | carry;
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
`ifdef CONVERTIDOR_BLANK_EN
                    bcd_d  = blank(shifted);
`else
                    bcd_d  = shifted;
`endif
                    overflow_d = ovf_scr_q | carry;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_convertidor_bcd_serial.sv
// Self-checking bench: a default-size converter and a 3-digit converter driven from vector tables.
module tb_convertidor_bcd_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [9:0]  bin_a, bin_b;
    logic        busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;
    logic [15:0] bcd_a;
    logic [11:0] bcd_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    convertidor_bcd_serial dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bin(bin_a),
        .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a)
    );

    convertidor_bcd_serial #(.WIDTH(10), .DIGITS(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bin(bin_b),
        .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b)
    );

    typedef struct {
        logic        sel;
        logic [9:0]  bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected output after optional leading-zero blanking.
    function automatic logic [15:0] exp_bcd(input logic [15:0] v, input int nd);
        logic [15:0] r;
        r = v;
`ifdef CONVERTIDOR_BLANK_EN
        begin
            logic nz;
            nz = 1'b0;
            for (int i = nd - 1; i >= 1; i--) begin
                if (v[4*i +: 4] != 4'd0) nz = 1'b1;
                if (!nz) r[4*i +: 4] = 4'hF;
            end
        end
`endif
        if (nd == 3) r[15:12] = 4'h0;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a conversion on the selected DUT; return cycles from acceptance to done.
    task automatic run(input logic sel, input logic [9:0] v, output int lat);
        if (sel) begin bin_b = v; start_b = 1'b1; end
        else     begin bin_a = v; start_a = 1'b1; end
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        bin_a   = 10'h3FF;
        bin_b   = 10'h3FF;
        lat = -1;
        for (int n = 1; n <= 14; n++) begin
            tick();
            if ((sel ? done_b : done_a) === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    int lat;
    int dones;

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; bin_a = '0; bin_b = '0;
        vecs[0]  = '{1'b0, 10'd0,    16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 10'd999,  16'h0999, 1'b0};
        vecs[2]  = '{1'b0, 10'd1023, 16'h1023, 1'b0};
        vecs[3]  = '{1'b0, 10'd7,    16'h0007, 1'b0};
        vecs[4]  = '{1'b0, 10'd100,  16'h0100, 1'b0};
        vecs[5]  = '{1'b0, 10'd58,   16'h0058, 1'b0};
        vecs[6]  = '{1'b1, 10'd1000, 16'h0000, 1'b1};
        vecs[7]  = '{1'b1, 10'd1015, 16'h0015, 1'b1};
        vecs[8]  = '{1'b1, 10'd999,  16'h0999, 1'b0};
        vecs[9]  = '{1'b1, 10'd5,    16'h0005, 1'b0};
        vecs[10] = '{1'b1, 10'd1023, 16'h0023, 1'b1};
        vecs[11] = '{1'b0, 10'd512,  16'h0512, 1'b0};

        tick(); tick();
        check("reset_busy", 32'(busy_a), 32'd0);
        check("reset_done", 32'(done_a), 32'd0);
        check("reset_bcd",  32'(bcd_a),  32'd0);
        check("reset_ovf",  32'(ovf_a),  32'd0);

        // Reset wins over a simultaneous start.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("rst_prio_busy", 32'(busy_a), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(busy_a), 32'd0);

        for (int i = 0; i < 12; i++) begin
            run(vecs[i].sel, vecs[i].bin, lat);
            check($sformatf("lat_%0d", i), 32'(lat), 32'd10);
            if (vecs[i].sel) begin
                check($sformatf("bcd_%0d", i), 32'(bcd_b), 32'(exp_bcd(vecs[i].bcd, 3)));
                check($sformatf("ovf_%0d", i), 32'(ovf_b), 32'(vecs[i].ovf));
                check($sformatf("busy_at_done_%0d", i), 32'(busy_b), 32'd0);
                tick();
                check($sformatf("done_width_%0d", i), 32'(done_b), 32'd0);
                check($sformatf("hold_bcd_%0d", i), 32'(bcd_b), 32'(exp_bcd(vecs[i].bcd, 3)));
            end else begin
                check($sformatf("bcd_%0d", i), 32'(bcd_a), 32'(exp_bcd(vecs[i].bcd, 4)));
                check($sformatf("ovf_%0d", i), 32'(ovf_a), 32'(vecs[i].ovf));
                check($sformatf("busy_at_done_%0d", i), 32'(busy_a), 32'd0);
                tick();
                check($sformatf("done_width_%0d", i), 32'(done_a), 32'd0);
                check($sformatf("hold_bcd_%0d", i), 32'(bcd_a), 32'(exp_bcd(vecs[i].bcd, 4)));
            end
        end

        // Second start during SHIFT is ignored; busy falls as done rises.
        bin_a = 10'd42; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("busy_after_accept", 32'(busy_a), 32'd1);
        tick(); tick();
        bin_a = 10'd500; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        dones = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (done_a) begin
                dones++;
                check("seq_busy_low", 32'(busy_a), 32'd0);
                check("seq_bcd", 32'(bcd_a), 32'(exp_bcd(16'h0042, 4)));
            end
        end
        check("seq_done_count", 32'(dones), 32'd1);

        // Reset at the 5th SHIFT cycle aborts the conversion.
        bin_a = 10'd777; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick(); tick(); tick(); tick();
        check("abort_busy_pre", 32'(busy_a), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_bcd",  32'(bcd_a),  32'd0);
        check("abort_ovf",  32'(ovf_a),  32'd0);
        dones = 0;
        for (int n = 0; n < 15; n++) begin
            if (done_a) dones++;
            tick();
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run(1'b0, 10'd321, lat);
        check("after_abort_lat", 32'(lat), 32'd10);
        check("after_abort_bcd", 32'(bcd_a), 32'(exp_bcd(16'h0321, 4)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors so far %0d", n_err);
        $fatal(1);
    end

endmodule
